// File: rtl/key_stream_loader.sv
// Bit-serial key loader for a key-locked netlist: receives an even-parity key frame
// over valid/ready, commits good frames atomically, holds a decoy otherwise, locks out on repeated failures.
module key_stream_loader #(
    parameter int                 KEY_W    = 4,
    parameter logic [KEY_W-1:0]   DECOY    = '0,
    parameter int                 MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid,
    output logic             err,
    output logic             lockout,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_fail_cnt
);

    // Handshake: a serial bit transfers on a rising edge where sin_valid && sin_ready;
    // sin_ready is registered and high only in SHIFT, sin_data is ignored otherwise.

    localparam int CNT_W = $clog2(KEY_W + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W:0]     r_shadow;
    logic [3:0]         r_fail_cnt;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_valid;
    logic               r_err;
    logic               r_lockout;
    logic               r_sin_ready;
    logic               r_busy;
    logic               w_xfer;
    logic               w_parity_ok;

    assign w_xfer      = sin_valid && r_sin_ready;
    assign w_parity_ok = (^r_shadow) == 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_fail_cnt  <= '0;
            r_key       <= DECOY;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_lockout   <= 1'b0;
            r_sin_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_key       <= DECOY;
                        r_key_valid <= 1'b0;
                    end else if (start) begin
                        r_state     <= SHIFT;
                        r_cnt       <= '0;
                        r_sin_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (clear) begin
                        r_state     <= IDLE;
                        r_key       <= DECOY;
                        r_key_valid <= 1'b0;
                        r_sin_ready <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_xfer) begin
                        r_shadow <= {r_shadow[KEY_W-1:0], sin_data};
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(KEY_W)) begin
                            r_state     <= CHECK;
                            r_sin_ready <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    // clear outranks the commit that would otherwise happen this edge
                    if (clear) begin
                        r_key       <= DECOY;
                        r_key_valid <= 1'b0;
                    end else if (w_parity_ok) begin
                        r_key       <= r_shadow[KEY_W:1];
                        r_key_valid <= 1'b1;
                        r_fail_cnt  <= '0;
                    end else begin
                        r_err      <= 1'b1;
                        r_fail_cnt <= r_fail_cnt + 4'd1;
                        if (r_fail_cnt == 4'(MAX_FAIL - 1)) begin
                            r_state     <= LOCKOUT;
                            r_key       <= DECOY;
                            r_key_valid <= 1'b0;
                            r_lockout   <= 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    r_state <= LOCKOUT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sin_ready    = r_sin_ready;
    assign key_o        = r_key;
    assign key_valid    = r_key_valid;
    assign err          = r_err;
    assign lockout      = r_lockout;
    assign busy         = r_busy;
    assign dbg_state    = r_state;
    assign dbg_fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_key_stream_loader.sv
// Self-checking bench for key_stream_loader: directed scenarios plus randomized frames
// compared against a frame-level model of the load/parity/lockout rules.
module tb_key_stream_loader;

    localparam int KEY_W    = 4;
    localparam int MAX_FAIL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic sin_valid = 1'b0;
    logic sin_data = 1'b0;
    logic sin_ready;
    logic [KEY_W-1:0] key_o;
    logic key_valid, err, lockout, busy;
    logic [1:0] dbg_state;
    logic [3:0] dbg_fail_cnt;

    int checks = 0;
    int errors = 0;

    logic [KEY_W-1:0] exp_key;
    logic exp_valid;
    logic exp_lock;
    logic exp_err;
    int exp_fail;

    key_stream_loader #(.KEY_W(KEY_W), .DECOY(4'b0000), .MAX_FAIL(MAX_FAIL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready),
        .key_o(key_o), .key_valid(key_valid), .err(err), .lockout(lockout),
        .busy(busy), .dbg_state(dbg_state), .dbg_fail_cnt(dbg_fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level reference: the frame is {key[3:0], parity}, good when its XOR is 0.
    task automatic model_reset();
        exp_key = 4'b0000; exp_valid = 1'b0; exp_lock = 1'b0; exp_fail = 0; exp_err = 1'b0;
    endtask

    task automatic model_frame(input logic [4:0] f);
        exp_err = 1'b0;
        if (exp_lock) return;
        if ((^f) == 1'b0) begin
            exp_key = f[4:1]; exp_valid = 1'b1; exp_fail = 0;
        end else begin
            exp_err = 1'b1;
            exp_fail = exp_fail + 1;
            if (exp_fail == MAX_FAIL) begin
                exp_lock = 1'b1; exp_key = 4'b0000; exp_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    // Issues start, then serves the frame MSB-first; returns #1 after the last-bit edge.
    task automatic send_bits(input logic [4:0] f, input bit gaps, output int rdy_cycles);
        int idx;
        int guard;
        bit xfer;
        idx = 4; guard = 0; rdy_cycles = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx >= 0 && guard < 64) begin
            sin_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sin_data  = f[idx];
            if (sin_ready) rdy_cycles++;
            xfer = sin_valid && sin_ready;
            @(posedge clk); #1;
            if (xfer) idx--;
            guard++;
        end
        sin_valid = 1'b0; sin_data = 1'b0;
        checks++;
        if (idx >= 0) begin
            errors++;
            $display("FAIL send_timeout: %0d bits left after %0d cycles, required 0", idx + 1, guard);
        end
    endtask

    task automatic send_frame(input logic [4:0] f, input bit gaps, output int rdy_cycles,
                              output logic rdy_in_check);
        send_bits(f, gaps, rdy_cycles);
        rdy_in_check = sin_ready;
        @(posedge clk); #1;
        model_frame(f);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (key_o !== 4'b0000) begin errors++; $display("FAIL reset_key: got %b want 0000", key_o); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout: got %b want 0", lockout); end
        checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL reset_sin_ready: got %b want 0", sin_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_good_load();
        int rdy;
        logic rdy_chk;
        send_frame(5'b10111, 1'b0, rdy, rdy_chk);
        checks++; if (rdy != 5) begin errors++; $display("FAIL good_ready_cycles: got %0d want 5", rdy); end
        checks++; if (rdy_chk !== 1'b0) begin errors++; $display("FAIL good_ready_in_check: got %b want 0", rdy_chk); end
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL good_key: got %b want %b", key_o, exp_key); end
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL good_key_valid: got %b want %b", key_valid, exp_valid); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL good_err: got %b want %b", err, exp_err); end
    endtask

    task automatic test_bad_then_good();
        int rdy;
        logic rdy_chk;
        send_frame(5'b01101, 1'b0, rdy, rdy_chk);
        checks++; if (err !== exp_err) begin errors++; $display("FAIL bad_err: got %b want %b", err, exp_err); end
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL bad_key_held: got %b want %b", key_o, exp_key); end
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL bad_valid_held: got %b want %b", key_valid, exp_valid); end
        checks++; if (dbg_fail_cnt !== 4'(exp_fail)) begin errors++; $display("FAIL bad_fail_cnt: got %0d want %0d", dbg_fail_cnt, exp_fail); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_pulse: got %b want 0", err); end
        send_frame(5'b01100, 1'b0, rdy, rdy_chk);
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL recover_key: got %b want %b", key_o, exp_key); end
        checks++; if (dbg_fail_cnt !== 4'(exp_fail)) begin errors++; $display("FAIL recover_fail_cnt: got %0d want %0d", dbg_fail_cnt, exp_fail); end
    endtask

    task automatic test_lockout();
        int rdy;
        logic rdy_chk;
        int ready_seen;
        logic [4:0] f;
        for (int n = 0; n < MAX_FAIL; n++) begin
            f[4:1] = 4'($urandom_range(0, 15));
            f[0] = ~(^f[4:1]);
            send_frame(f, 1'b0, rdy, rdy_chk);
            checks++; if (lockout !== exp_lock) begin errors++; $display("FAIL lock_flag_%0d: got %b want %b", n, lockout, exp_lock); end
        end
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL lock_key: got %b want %b", key_o, exp_key); end
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL lock_valid: got %b want %b", key_valid, exp_valid); end
        ready_seen = 0;
        start = 1'b1; clear = 1'b1; sin_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sin_data = 1'($urandom_range(0, 1));
            if (c == 1) clear = 1'b0;
            @(posedge clk); #1;
            if (sin_ready || busy) ready_seen++;
        end
        start = 1'b0; sin_valid = 1'b0;
        checks++; if (ready_seen != 0) begin errors++; $display("FAIL lock_ready: got %0d ready cycles want 0", ready_seen); end
        checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL lock_sticky: got %b want 1", lockout); end
        do_reset();
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL lock_reset: got %b want 0", lockout); end
        checks++; if (key_o !== 4'b0000) begin errors++; $display("FAIL lock_reset_key: got %b want 0000", key_o); end
    endtask

    task automatic test_gaps();
        int rdy;
        logic rdy_chk;
        send_frame(5'b01010, 1'b1, rdy, rdy_chk);
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL gaps_key: got %b want %b", key_o, exp_key); end
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL gaps_valid: got %b want %b", key_valid, exp_valid); end
    endtask

    task automatic test_clear_idle();
        start = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        exp_key = 4'b0000; exp_valid = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL clr_idle_state: got %0d want 0", dbg_state); end
        checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL clr_idle_ready: got %b want 0", sin_ready); end
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL clr_idle_key: got %b want %b", key_o, exp_key); end
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL clr_idle_valid: got %b want %b", key_valid, exp_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int rdy;
        logic rdy_chk;
        send_frame(5'b10111, 1'b0, rdy, rdy_chk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sin_valid = 1'b1; sin_data = 1'b1;
        @(posedge clk); #1;
        sin_data = 1'b0;
        @(posedge clk); #1;
        sin_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (key_o !== 4'b0000) begin errors++; $display("FAIL midrst_key: got %b want 0000", key_o); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
        checks++; if (sin_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ready=%b busy=%b want 0 0", sin_ready, busy); end
        do_reset();
    endtask

    task automatic test_clear_check();
        int rdy;
        logic rdy_chk;
        int fail_before;
        send_frame(5'b10111, 1'b0, rdy, rdy_chk);
        fail_before = exp_fail;
        send_bits(5'b11000, 1'b0, rdy);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_key = 4'b0000; exp_valid = 1'b0;
        checks++; if (key_o !== exp_key) begin errors++; $display("FAIL clr_chk_key: got %b want %b", key_o, exp_key); end
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL clr_chk_valid: got %b want %b", key_valid, exp_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_chk_err: got %b want 0", err); end
        checks++; if (dbg_fail_cnt !== 4'(fail_before)) begin errors++; $display("FAIL clr_chk_fail_cnt: got %0d want %0d", dbg_fail_cnt, fail_before); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL clr_chk_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_random();
        int rdy;
        logic rdy_chk;
        logic [4:0] f;
        for (int n = 0; n < 30; n++) begin
            f[4:1] = 4'($urandom_range(0, 15));
            f[0] = (^f[4:1]) ^ ($urandom_range(0, 3) == 0);
            send_frame(f, 1'($urandom_range(0, 1)), rdy, rdy_chk);
            checks++; if (key_o !== exp_key) begin errors++; $display("FAIL rnd_key_%0d: got %b want %b", n, key_o, exp_key); end
            checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid_%0d: got %b want %b", n, key_valid, exp_valid); end
            checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err_%0d: got %b want %b", n, err, exp_err); end
            checks++; if (lockout !== exp_lock) begin errors++; $display("FAIL rnd_lock_%0d: got %b want %b", n, lockout, exp_lock); end
            checks++; if (dbg_fail_cnt !== 4'(exp_fail)) begin errors++; $display("FAIL rnd_fail_cnt_%0d: got %0d want %0d", n, dbg_fail_cnt, exp_fail); end
            if (exp_lock) do_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_load();
        test_bad_then_good();
        test_lockout();
        test_gaps();
        test_clear_idle();
        test_reset_mid_frame();
        test_clear_check();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_stream_loader.md
Name: key_stream_loader

Overview:
- Feeds the key inputs of a key-locked combinational netlist: the D_x key-bit bundle that drives the locking MUXes.
- Receives a key frame bit-serially over a valid/ready handshake and checks it with an even-parity bit.
- A good frame is committed atomically to the key outputs.
- Outputs hold a decoy key until the first good load. Repeated bad frames force a sticky lockout.

Parameters:
- KEY_W, 4, number of key bits driven to the locked netlist.
- DECOY, 0 (KEY_W bits), key value driven at reset, after clear, and during lockout.
- MAX_FAIL, 3, consecutive parity failures that trigger lockout; range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- clear  input  1  synchronous abort/unload; honoured in IDLE, SHIFT and CHECK.
- sin_valid  input  1  serial bit valid.
- sin_data  input  1  serial key bit.
- sin_ready  output  1  loader accepts a bit this cycle; high only in SHIFT.
- key_o  output  KEY_W  committed key bundle (bit i drives D_i).
- key_valid  output  1  key_o holds a parity-checked key.
- err  output  1  one-cycle pulse on a parity failure.
- lockout  output  1  sticky lockout indicator.
- busy  output  1  high in SHIFT or CHECK.

Behaviour:
- Reset (async assert, sync deassert by the integrator) sets:
  - state IDLE
  - key_o = DECOY
  - key_valid = 0, err = 0, lockout = 0, sin_ready = 0, busy = 0
  - bit counter = 0, fail_cnt = 0, shadow register = 0
- Reset mid-frame discards all partial data. Reset always recovers from LOCKOUT.
- A bit transfers on a rising edge where sin_valid & sin_ready. sin_data is ignored otherwise.
- Frame format is KEY_W+1 bits:
  - First bit = key[KEY_W-1], continuing MSB-first down to key[0].
  - Last bit = parity, chosen so the XOR of all KEY_W+1 bits is 0 (even parity).
- IDLE:
  - sin_ready = 0.
  - start=1 -> SHIFT, counter cleared.
  - start and clear both high -> clear wins; stay in IDLE.
- SHIFT:
  - sin_ready = 1.
  - Each transfer shifts sin_data into the shadow register LSB and increments the counter.
  - Gaps (sin_valid=0) stall with no timeout.
  - The transfer that makes counter = KEY_W+1 -> CHECK.
  - start is ignored in this state.
- CHECK (exactly one cycle, sin_ready = 0):
  - Parity OK:
    - key_o <= shadow[KEY_W:1], key_valid <= 1, fail_cnt <= 0.
    - -> IDLE.
  - Parity bad:
    - err pulses high for this edge's following cycle.
    - key_o and key_valid keep their previous committed values.
    - fail_cnt increments.
    - If the new fail_cnt == MAX_FAIL -> LOCKOUT, else -> IDLE.
- Latency: last-bit transfer at edge k; key_o, key_valid and err update at edge k+1. The next start is accepted at edge k+2 at the earliest.
- clear in IDLE, SHIFT or CHECK:
  - -> IDLE; key_o = DECOY; key_valid = 0; partial frame dropped.
  - fail_cnt is unchanged.
  - clear beats the CHECK commit in the same cycle.
- LOCKOUT:
  - key_o = DECOY, key_valid = 0, lockout = 1, sin_ready = 0, busy = 0.
  - start and clear are ignored. Exit only via rst_n.
- key_o changes only at commit, clear, lockout entry or reset. It never shows a partial shadow value.
- All outputs are registered; no combinational input-to-output paths.

Test Plan (KEY_W=4, DECOY=0000, MAX_FAIL=3):
- Reset then idle 10 cycles -> key_o=0000; key_valid, err, lockout and sin_ready all 0.
- start, then continuous bits 1,0,1,1,1 -> sin_ready high for 5 cycles; at the edge after the 5th bit, key_o=1011 and key_valid=1; err stays 0.
- After loading 1011, send frame 0,1,1,0,1 (bad parity) -> err pulses once; key_o stays 1011, key_valid stays 1; fail_cnt=1. Then a good frame 0,1,1,0,0 -> key_o=0110 and fail_cnt resets.
- Three consecutive bad frames -> lockout=1 one edge after the third CHECK; key_o=0000, key_valid=0. A further start plus bits leaves sin_ready=0. rst_n pulse -> lockout=0.
- sin_valid toggling 1,0,0,1,... with bits 0,1,0,1,0 -> only valid cycles count; key_o=0101 after the 5th accepted bit.
- Two separate cases, each starting with key 1011 loaded: (a) assert rst_n low after 2 of 5 bits -> immediate DECOY and IDLE; (b) assert clear during CHECK -> key_o=0000, key_valid=0, no commit.
